// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
// Op encodings follow funct3 of the M-extension instructions.
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [31:0] DIV_BY_ZERO = 32'hFFFF_FFFF;
    localparam logic [31:0] SIGNED_MIN  = 32'h8000_0000;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: shift-add multiply and restoring divide on magnitudes,
// sharing the operand registers, iteration counter and final sign-fixup negation.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     Start,
    input  logic [OPCODE_LENGTH-1:0] Funct3,
    input  logic [DATA_WIDTH-1:0]    SrcA,
    input  logic [DATA_WIDTH-1:0]    SrcB,
    input  logic                     Flush,
    output logic                     Busy,
    output logic                     StallReq,
    output logic                     Done,
    output logic [DATA_WIDTH-1:0]    Result
);

    localparam int CW = $clog2(DATA_WIDTH);

    state_e                state, state_nx;
    logic [CW-1:0]         counter;
    logic [2:0]            op;
    logic                  neg;
    logic [DATA_WIDTH-1:0] hi, lo, opb;

    // Operand decode on the live inputs, used only on the accept edge
    op_e                   f_in;
    logic                  a_sgn, b_sgn, a_neg, b_neg, dbz, ovf, special, accept, last;
    logic [DATA_WIDTH-1:0] a_mag, b_mag, spec_res;

    always_comb begin
        f_in    = op_e'(Funct3);
        a_sgn   = (f_in inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
        b_sgn   = (f_in inside {OP_MUL, OP_MULH, OP_DIV, OP_REM});
        a_neg   = a_sgn & SrcA[DATA_WIDTH-1];
        b_neg   = b_sgn & SrcB[DATA_WIDTH-1];
        a_mag   = a_neg ? (~SrcA + 1'b1) : SrcA;
        b_mag   = b_neg ? (~SrcB + 1'b1) : SrcB;
        dbz     = Funct3[2] & (SrcB == '0);
        ovf     = (f_in inside {OP_DIV, OP_REM}) & (SrcA == SIGNED_MIN) & (SrcB == '1);
        special = dbz | ovf;
        if (dbz)
            spec_res = Funct3[1] ? SrcA : DIV_BY_ZERO;
        else
            spec_res = Funct3[1] ? '0 : SIGNED_MIN;
        accept  = (state == IDLE) & Start & ~Flush;
        last    = (state == CALC) & ~Flush & (counter == CW'(DATA_WIDTH - 1));
    end

    // One iteration of either algorithm; {hi,lo} is product or {remainder,quotient}
    logic [DATA_WIDTH:0]   sum, shifted;
    logic [DATA_WIDTH-1:0] hi_nx, lo_nx;

    always_comb begin
        sum     = {1'b0, hi} + (lo[0] ? {1'b0, opb} : '0);
        shifted = {hi, lo[DATA_WIDTH-1]};
        if (op[2]) begin
            if (shifted >= {1'b0, opb}) begin
                hi_nx = shifted[DATA_WIDTH-1:0] - opb;
                lo_nx = {lo[DATA_WIDTH-2:0], 1'b1};
            end else begin
                hi_nx = shifted[DATA_WIDTH-1:0];
                lo_nx = {lo[DATA_WIDTH-2:0], 1'b0};
            end
        end else begin
            hi_nx = sum[DATA_WIDTH:1];
            lo_nx = {sum[0], lo[DATA_WIDTH-1:1]};
        end
    end

    // Sign fixup: negating the high half of a 2W product only carries in when the low half is zero
    logic                  sel_hi, cin;
    logic [DATA_WIDTH-1:0] raw, fixed;

    always_comb begin
        sel_hi = op[2] ? op[1] : (op[1:0] != 2'b00);
        raw    = sel_hi ? hi_nx : lo_nx;
        cin    = (~op[2] & sel_hi) ? (lo_nx == '0) : 1'b1;
        fixed  = neg ? (~raw + {{(DATA_WIDTH-1){1'b0}}, cin}) : raw;
    end

    always_ff @(posedge clk) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = special ? DONE : CALC;
            CALC:    if (Flush) state_nx = IDLE;
                     else if (last) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            counter <= '0;
            op      <= '0;
            neg     <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            opb     <= '0;
            Result  <= '0;
        end else if (accept) begin
            counter <= '0;
            op      <= Funct3;
            neg     <= (Funct3[2] & Funct3[1]) ? a_neg : (a_neg ^ b_neg);
            hi      <= '0;
            lo      <= Funct3[2] ? a_mag : b_mag;
            opb     <= Funct3[2] ? b_mag : a_mag;
            if (special)
                Result <= spec_res;
        end else if (state == CALC && !Flush) begin
            counter <= counter + 1'b1;
            hi      <= hi_nx;
            lo      <= lo_nx;
            if (last)
                Result <= fixed;
        end
    end

    assign Busy     = (state == CALC);
    assign Done     = (state == DONE);
    assign StallReq = reset & (((state == IDLE) & Start) | (state == CALC));

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit; a negedge monitor pops the expected-result
// queue on every Done pulse while the stimulus thread checks latency and handshakes.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        Start = 1'b0;
    logic        Flush = 1'b0;
    logic [2:0]  Funct3 = 3'b000;
    logic [31:0] SrcA = '0;
    logic [31:0] SrcB = '0;
    logic        Busy, StallReq, Done;
    logic [31:0] Result;

    muldiv_unit #(.DATA_WIDTH(32), .OPCODE_LENGTH(3)) dut (
        .clk(clk), .reset(reset), .Start(Start), .Funct3(Funct3),
        .SrcA(SrcA), .SrcB(SrcB), .Flush(Flush),
        .Busy(Busy), .StallReq(StallReq), .Done(Done), .Result(Result)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] expq[$];
    string       nameq[$];
    string       mon_nm;
    logic [31:0] last_res = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (reset && Done) begin
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got Result %h with no op pending", Result);
            end else begin
                mon_nm = nameq.pop_front();
                chk(mon_nm, Result, expq.pop_front());
                chk({mon_nm, "_stallreq_done"}, {31'b0, StallReq}, 32'd0);
            end
        end
    end

    // Called at the first negedge after the accept edge; lat counts edges from accept to Done
    task automatic wait_done(input string nm, input int lat, input bit scramble);
        int n;
        n = 1;
        while (!Done && n < 100) begin
            @(negedge clk);
            if (scramble) begin
                SrcA   = $urandom;
                SrcB   = $urandom;
                Funct3 = 3'($urandom);
            end
            n++;
        end
        chk({nm, "_latency"}, 32'(n), 32'(lat));
    endtask

    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int lat, input string nm);
        @(negedge clk);
        Funct3 = f; SrcA = a; SrcB = b; Start = 1'b1;
        expq.push_back(exp);
        nameq.push_back(nm);
        last_res = exp;
        #1 chk({nm, "_stallreq_accept"}, {31'b0, StallReq}, 32'd1);
        @(negedge clk);
        Start = 1'b0;
        if (lat > 1) chk({nm, "_busy"}, {31'b0, Busy}, 32'd1);
        SrcA = $urandom; SrcB = $urandom; Funct3 = 3'($urandom);
        wait_done(nm, lat, 1'b1);
    endtask

    initial begin
        // Reset holds everything idle even with Start asserted
        reset = 1'b0; Start = 1'b1; Funct3 = 3'b000; SrcA = 32'd5; SrcB = 32'd3;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", {31'b0, Busy}, 32'd0);
        chk("rst_done", {31'b0, Done}, 32'd0);
        chk("rst_stallreq", {31'b0, StallReq}, 32'd0);
        chk("rst_result", Result, 32'd0);
        reset = 1'b1;
        expq.push_back(32'd15);
        nameq.push_back("rst_mul");
        last_res = 32'd15;
        @(negedge clk);
        Start = 1'b0;
        chk("rst_accept_busy", {31'b0, Busy}, 32'd1);
        wait_done("rst_mul", 33, 1'b1);

        // Multiply
        run_op(3'b000, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, "mul");
        run_op(3'b001, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFFF, 33, "mulh");
        run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, "mulhu");
        run_op(3'b010, 32'hFFFF_FFFF, 32'd2,        32'hFFFF_FFFF, 33, "mulhsu");
        run_op(3'b000, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33, "mul_min");
        run_op(3'b001, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 33, "mulh_min");

        // Divide
        run_op(3'b100, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFA, 33, "div");
        run_op(3'b110, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFE, 33, "rem");
        run_op(3'b101, 32'd100,       32'd7, 32'd14,        33, "divu");
        run_op(3'b111, 32'd100,       32'd7, 32'd2,         33, "remu");

        // Special cases complete one edge after accept
        run_op(3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF, 1, "divu_zero");
        run_op(3'b111, 32'd5,         32'd0,         32'd5,         1, "remu_zero");
        run_op(3'b100, 32'hFFFF_FFEC, 32'd0,         32'hFFFF_FFFF, 1, "div_zero");
        run_op(3'b110, 32'hFFFF_FFEC, 32'd0,         32'hFFFF_FFEC, 1, "rem_zero");
        run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "div_ovf");
        run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1, "rem_ovf");

        // Flush in IDLE blocks acceptance
        @(negedge clk);
        Funct3 = 3'b000; SrcA = 32'd9; SrcB = 32'd9; Start = 1'b1; Flush = 1'b1;
        @(negedge clk);
        chk("flush_idle_busy", {31'b0, Busy}, 32'd0);
        Start = 1'b0; Flush = 1'b0;

        // Flush on the 10th CALC cycle kills the op; no Done, Result held
        @(negedge clk);
        Funct3 = 3'b000; SrcA = 32'd9; SrcB = 32'd9; Start = 1'b1;
        @(negedge clk);
        Start = 1'b0;
        repeat (9) @(negedge clk);
        chk("flush_calc_busy", {31'b0, Busy}, 32'd1);
        Flush = 1'b1;
        @(negedge clk);
        chk("flush_busy", {31'b0, Busy}, 32'd0);
        chk("flush_done", {31'b0, Done}, 32'd0);
        chk("flush_result_held", Result, last_res);
        Flush = 1'b0;
        run_op(3'b011, 32'd1000, 32'd1000, 32'd0, 33, "post_flush_mulhu");
        run_op(3'b000, 32'd1000, 32'd1000, 32'd1_000_000, 33, "post_flush_mul");

        // Back-to-back: Start held high, second op accepted in the IDLE cycle after Done
        @(negedge clk);
        Funct3 = 3'b000; SrcA = 32'd3; SrcB = 32'd5; Start = 1'b1;
        expq.push_back(32'd15);
        nameq.push_back("b2b_first");
        @(negedge clk);
        wait_done("b2b_first", 33, 1'b0);
        SrcA = 32'd100; SrcB = 32'd100;
        expq.push_back(32'd10000);
        nameq.push_back("b2b_second");
        @(negedge clk);
        chk("b2b_idle_busy", {31'b0, Busy}, 32'd0);
        chk("b2b_idle_stallreq", {31'b0, StallReq}, 32'd1);
        @(negedge clk);
        chk("b2b_accept_busy", {31'b0, Busy}, 32'd1);
        Start = 1'b0;
        wait_done("b2b_second", 33, 1'b1);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 32'(expq.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
